// File: rtl/conv3x3_filter.sv
// 3x3 convolution with loadable signed coefficients: multiply, sum, then
// round/shift/saturate to 8 bits, with a per-frame output counter.
module conv3x3_filter #(
  parameter int SHIFT        = 4,
  parameter int FRAME_PIXELS = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] pixel1,
  input  logic [7:0] pixel2,
  input  logic [7:0] pixel3,
  input  logic [7:0] pixel4,
  input  logic [7:0] pixel5,
  input  logic [7:0] pixel6,
  input  logic [7:0] pixel7,
  input  logic [7:0] pixel8,
  input  logic [7:0] pixel9,
  input  logic       coef_load,
  input  logic [3:0] coef_addr,
  input  logic [7:0] coef_data,
  output logic       out_valid,
  output logic [7:0] out_pixel,
  output logic       frame_done,
  output logic [11:0] out_count
);

  // Handshake: in_valid qualifies the window for one cycle; there is no ready,
  // every valid window is accepted and emerges exactly 3 cycles later.

  localparam logic [8:0][7:0] COEF_RST = {8'd1, 8'd2, 8'd1,
                                          8'd2, 8'd4, 8'd2,
                                          8'd1, 8'd2, 8'd1};
  localparam logic signed [21:0] RND  = 22'(((1 << SHIFT) >> 1));
  localparam logic [11:0]        LAST = 12'(FRAME_PIXELS - 1);

  logic [8:0][7:0]    pix;
  logic signed [7:0]  coef   [9];
  logic signed [16:0] prod_d [9];
  logic signed [16:0] prod_q [9];
  logic signed [20:0] sum_d;
  logic signed [20:0] sum_q;
  logic signed [21:0] rnd_d;
  logic signed [21:0] shf_d;
  logic [7:0]         sat_d;
  logic               s1_valid;
  logic               s2_valid;

  assign pix = {pixel9, pixel8, pixel7, pixel6, pixel5,
                pixel4, pixel3, pixel2, pixel1};

  // Coefficient file; S1 samples the pre-write value in the write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) coef[k] <= $signed(COEF_RST[k]);
    end else if (coef_load && coef_addr < 4'd9) begin
      coef[coef_addr] <= $signed(coef_data);
    end
  end

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_d[k] = $signed({9'b0, pix[k]}) * $signed({{9{coef[k][7]}}, coef[k]});
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < 9; k++) begin
      sum_d = sum_d + $signed({{4{prod_q[k][16]}}, prod_q[k]});
    end
  end

  always_comb begin
    rnd_d = $signed({sum_q[20], sum_q}) + RND;
    shf_d = rnd_d >>> SHIFT;
    sat_d = shf_d[7:0];
    if (shf_d < 0)            sat_d = 8'd0;
    else if (shf_d > 22'sd255) sat_d = 8'd255;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_pixel  <= 8'd0;
      frame_done <= 1'b0;
      out_count  <= 12'd0;
      sum_q      <= '0;
      for (int k = 0; k < 9; k++) prod_q[k] <= '0;
    end else begin
      s1_valid   <= in_valid;
      s2_valid   <= s1_valid;
      out_valid  <= s2_valid;
      frame_done <= s2_valid && (out_count == LAST);
      if (in_valid) begin
        for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
      end
      if (s1_valid) sum_q <= sum_d;
      if (s2_valid) begin
        out_pixel <= sat_d;
        out_count <= (out_count == LAST) ? 12'd0 : out_count + 12'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_filter.sv
// Directed bench for conv3x3_filter: vector table with hand-computed results
// plus sequences for coefficient timing, bubbles, reset and frame wrap.
module tb_conv3x3_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8, pixel9;
  logic       coef_load = 1'b0;
  logic [3:0] coef_addr = 4'd0;
  logic [7:0] coef_data = 8'd0;
  logic       out_valid;
  logic [7:0] out_pixel;
  logic       frame_done;
  logic [11:0] out_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string           name;
    logic [8:0][7:0] coef;
    logic [8:0][7:0] pix;
    logic [7:0]      exp;
  } vec_t;

  vec_t vecs[9];

  conv3x3_filter #(.SHIFT(4), .FRAME_PIXELS(4096)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .pixel1(pixel1), .pixel2(pixel2), .pixel3(pixel3),
    .pixel4(pixel4), .pixel5(pixel5), .pixel6(pixel6),
    .pixel7(pixel7), .pixel8(pixel8), .pixel9(pixel9),
    .coef_load(coef_load), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_pixel(out_pixel),
    .frame_done(frame_done), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_pix(input logic [8:0][7:0] p);
    {pixel9, pixel8, pixel7, pixel6, pixel5, pixel4, pixel3, pixel2, pixel1} = p;
  endtask

  function automatic logic [8:0][7:0] fill(input logic [7:0] v);
    logic [8:0][7:0] r;
    for (int k = 0; k < 9; k++) r[k] = v;
    return r;
  endfunction

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic load_coefs(input logic [8:0][7:0] c);
    for (int k = 0; k < 9; k++) begin
      coef_load = 1'b1;
      coef_addr = 4'(k);
      coef_data = c[k];
      @(posedge clk); #1;
    end
    coef_load = 1'b0;
  endtask

  task automatic run_window(input string name, input logic [8:0][7:0] p, input logic [7:0] exp);
    set_pix(p);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({name, "_early_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_pixel"}, 32'(out_pixel), 32'(exp));
  endtask

  logic [8:0][7:0] seq19;
  int n_out, done_cnt, done_at;

  initial begin
    seq19 = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    // coef/pix literals list index 8 first, index 0 last.
    vecs[0] = '{"defaults_ramp", {8'd1,8'd2,8'd1,8'd2,8'd4,8'd2,8'd1,8'd2,8'd1}, seq19, 8'd5};
    vecs[1] = '{"sat_high", fill(8'd8), fill(8'd255), 8'd255};
    vecs[2] = '{"neg_clamp", {8'd0,8'd0,8'd0,8'd0,8'hF0,8'd0,8'd0,8'd0,8'd0}, {8'd200,8'd200,8'd200,8'd200,8'd50,8'd200,8'd200,8'd200,8'd200}, 8'd0};
    vecs[3] = '{"identity", {8'd0,8'd0,8'd0,8'd0,8'd16,8'd0,8'd0,8'd0,8'd0}, fill(8'd37), 8'd37};
    vecs[4] = '{"sobel_pos", {8'd1,8'd0,8'hFF,8'd2,8'd0,8'hFE,8'd1,8'd0,8'hFF}, {8'd200,8'd99,8'd10,8'd200,8'd99,8'd10,8'd200,8'd99,8'd10}, 8'd48};
    vecs[5] = '{"sobel_neg", {8'd1,8'd0,8'hFF,8'd2,8'd0,8'hFE,8'd1,8'd0,8'hFF}, {8'd10,8'd99,8'd200,8'd10,8'd99,8'd200,8'd10,8'd99,8'd200}, 8'd0};
    vecs[6] = '{"max_pos", fill(8'd127), fill(8'd255), 8'd255};
    vecs[7] = '{"max_neg", fill(8'h80), fill(8'd255), 8'd0};
    vecs[8] = '{"just_256", {8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd1,8'd16}, {8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd16,8'd255}, 8'd255};

    set_pix(fill(8'd0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pixel", 32'(out_pixel), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    rst_n = 1'b1;

    run_window("first_100", fill(8'd100), 8'd100);

    for (int i = 0; i < 9; i++) begin
      load_coefs(vecs[i].coef);
      run_window(vecs[i].name, vecs[i].pix, vecs[i].exp);
    end

    // Rounding edge: 7+8 rounds down, 8+8 rounds up.
    load_coefs({8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd1});
    run_window("round_down", fill(8'd7), 8'd0);
    run_window("round_up", fill(8'd8), 8'd1);

    // Out-of-range address must not alias onto index 4.
    load_coefs({8'd0,8'd0,8'd0,8'd0,8'd16,8'd0,8'd0,8'd0,8'd0});
    coef_load = 1'b1; coef_addr = 4'd12; coef_data = 8'h80;
    @(posedge clk); #1;
    coef_load = 1'b0;
    run_window("addr_ignored", fill(8'd50), 8'd50);

    // Write in the same cycle as a window: that window keeps the old coefficient.
    set_pix(fill(8'd50));
    in_valid = 1'b1; coef_load = 1'b1; coef_addr = 4'd4; coef_data = 8'd0;
    @(posedge clk); #1;
    coef_load = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("same_cycle_old_valid", 32'(out_valid), 32'd1);
    check("same_cycle_old_pixel", 32'(out_pixel), 32'd50);
    @(posedge clk); #1;
    check("same_cycle_new_valid", 32'(out_valid), 32'd1);
    check("same_cycle_new_pixel", 32'(out_pixel), 32'd0);

    // Bubble pattern 1,0,1 under default coefficients.
    load_coefs({8'd1,8'd2,8'd1,8'd2,8'd4,8'd2,8'd1,8'd2,8'd1});
    set_pix(fill(8'd10)); in_valid = 1'b1;
    @(posedge clk); #1;
    set_pix(fill(8'd77)); in_valid = 1'b0;
    @(posedge clk); #1;
    set_pix(fill(8'd20)); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bubble_o1_valid", 32'(out_valid), 32'd1);
    check("bubble_o1_pixel", 32'(out_pixel), 32'd10);
    @(posedge clk); #1;
    check("bubble_o2_valid", 32'(out_valid), 32'd0);
    check("bubble_o2_pixel", 32'(out_pixel), 32'd10);
    check("bubble_o2_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1;
    check("bubble_o3_valid", 32'(out_valid), 32'd1);
    check("bubble_o3_pixel", 32'(out_pixel), 32'd20);

    // Reset mid-stream with custom coefficients (all 3).
    load_coefs(fill(8'd3));
    set_pix(seq19); in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    check("pre_reset_pixel", 32'(out_pixel), 32'd8);
    #2; rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_pixel", 32'(out_pixel), 32'd0);
    check("async_rst_count", 32'(out_count), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("no_stale_valid", 32'(out_valid), 32'd0);
    end
    run_window("defaults_back", seq19, 8'd5);

    // Full frame of 4096 windows (all 16, defaults -> 16).
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    set_pix(fill(8'd16));
    n_out = 0; done_cnt = 0; done_at = 0;
    for (int c = 0; c < 4096 + 3; c++) begin
      in_valid = (c < 4096);
      @(posedge clk); #1;
      if (out_valid) begin
        n_out++;
        if (frame_done) begin
          done_cnt++;
          done_at = n_out;
        end
        if (n_out == 100) check("count_mid", 32'(out_count), 32'd100);
      end else if (frame_done) begin
        done_cnt++;
      end
    end
    in_valid = 1'b0;
    check("frame_outputs", 32'(n_out), 32'd4096);
    check("frame_done_pulses", 32'(done_cnt), 32'd1);
    check("frame_done_position", 32'(done_at), 32'd4096);
    check("frame_count_wrapped", 32'(out_count), 32'd0);
    check("frame_last_pixel", 32'(out_pixel), 32'd16);
    run_window("after_frame", fill(8'd16), 8'd16);
    check("after_frame_count", 32'(out_count), 32'd1);
    check("after_frame_done", 32'(frame_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
